id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- Decode-to-execute pipeline register of the RISC-V core; captures the Register_File read data and decoded control for one instruction and presents it to the execute stage.
- Single-entry valid/ready buffer.
- Performs write-back bypass into the captured operands, because the register file writes on the clock edge while its reads are combinational.
- Detects load-use hazards and inserts bubbles; supports flush on branch/jump redirect.

Parameters:
- XLEN, 32, data/operand/PC width
- ALUW, 4, width of ALU control field

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  decode holds a valid instruction
- in_ready  out  1  stage can accept this cycle (combinational)
- pc_in  in  XLEN  instruction PC
- rs1_in, rs2_in  in  5 each  source register indices
- rd_in  in  5  destination index
- rd1_in, rd2_in  in  XLEN each  register file read data
- imm_in  in  XLEN  sign-extended immediate
- ctrl_in  in  8  {reg_write, mem_read, mem_write, alu_src, branch, jump, result_src[1:0]}
- alu_ctrl_in  in  ALUW  ALU operation
- wb_we  in  1  write-back write enable (same signal as register file WE3)
- wb_rd  in  5  write-back index
- wb_data  in  XLEN  write-back data
- flush  in  1  discard held and incoming instruction
- out_valid  out  1  execute-side valid
- out_ready  in  1  execute accepts
- pc_q, rd1_q, rd2_q, imm_q  out  XLEN each  registered fields
- rs1_q, rs2_q, rd_q  out  5 each  registered indices
- ctrl_q  out  8  registered control
- alu_ctrl_q  out  ALUW  registered ALU control
- load_use_stall  out  1  hazard indicator to fetch/decode (combinational)
- bubble_count  out  16  saturating count of inserted bubbles

Behaviour:
- Reset: out_valid=0; all data/index/control outputs=0; bubble_count=0. Applies asynchronously, mid-transfer included.
- load_use_stall = in_valid & out_valid & ctrl_q.mem_read & rd_q!=0 & (rd_q==rs1_in | rd_q==rs2_in).
- in_ready = (!out_valid | out_ready) & !load_use_stall & !flush.
- Capture (in_valid & in_ready):
  - All fields load next edge; out_valid=1.
  - rd1 captured as wb_data if wb_we & wb_rd!=0 & wb_rd==rs1_in, else rd1_in; rs2 likewise.
  - rs index 0 always captures 0 regardless of rd1_in/rd2_in.
- Drain without capture (out_valid & out_ready & !in_valid): out_valid=0 next edge; data fields hold.
- Bubble (out_ready & load_use_stall):
  - out_valid=0; held instruction consumed.
  - Next cycle the stall term drops and the decode instruction is captured with the load result via bypass.
  - bubble_count +1, saturating at 0xFFFF.
- Hold (out_valid & !out_ready):
  - All fields held.
  - If wb_we & wb_rd!=0 & wb_rd==rs1_q, rd1_q updates to wb_data; same for rd2_q/rs2_q.
- Flush: highest priority. out_valid=0 next edge, no capture that cycle, no bubble count; data fields hold.
- Simultaneous flush and out_ready: flush wins; the held instruction counts as consumed by execute that cycle.
- Latency: one cycle from capture to out_valid.
- Throughput: one instruction per cycle with out_ready=1 and no hazard.
- No internal state beyond one entry plus counter.

Test Plan:
- Reset mid-hold, with out_valid=1 and rd1_q=0x1234 -> all outputs 0 immediately, out_valid=0.
- Capture pc_in=0x100, rs1=5, rd1_in=0xA, wb_we=1, wb_rd=5, wb_data=0xBEEF -> next cycle out_valid=1, rd1_q=0xBEEF, pc_q=0x100.
- Hold with out_ready=0, rs2_q=7; pulse wb_we, wb_rd=7, wb_data=0x55 -> rd2_q=0x55; in_ready=0; other fields unchanged.
- Load in stage (mem_read=1, rd_q=3), decode rs1_in=3, out_ready=1:
  - load_use_stall=1, in_ready=0.
  - Next cycle out_valid=0, bubble_count=1.
  - Following cycle captures with bypassed load data.
- Same-index case: rd_q=0 with mem_read=1, rs1_in=0 -> no stall; rd1_q captures 0 even when rd1_in=0xFFFF_FFFF.
- flush=1 with in_valid=1 and out_valid=1 -> in_ready=0; next cycle out_valid=0; bubble_count unchanged.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// Decode-to-execute pipeline register: a single-entry valid/ready buffer
// holding the operands and decoded control of one instruction. It forwards
// the write-back result into the operands, both as they are captured and
// while they are held. It also detects load-use hazards and inserts a
// bubble for each one.
module id_ex_stage_reg #(
  parameter int XLEN = 32,
  parameter int ALUW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc_in,
  input  logic [4:0]      rs1_in,
  input  logic [4:0]      rs2_in,
  input  logic [4:0]      rd_in,
  input  logic [XLEN-1:0] rd1_in,
  input  logic [XLEN-1:0] rd2_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [7:0]      ctrl_in,
  input  logic [ALUW-1:0] alu_ctrl_in,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_q,
  output logic [XLEN-1:0] rd1_q,
  output logic [XLEN-1:0] rd2_q,
  output logic [XLEN-1:0] imm_q,
  output logic [4:0]      rs1_q,
  output logic [4:0]      rs2_q,
  output logic [4:0]      rd_q,
  output logic [7:0]      ctrl_q,
  output logic [ALUW-1:0] alu_ctrl_q,
  output logic            load_use_stall,
  output logic [15:0]     bubble_count
);

  // ctrl layout: {reg_write, mem_read, mem_write, alu_src, branch, jump, result_src[1:0]}
  localparam int MEM_READ_BIT = 6;

  // Operand seen by a newly captured instruction. x0 always reads as zero.
  // A write-back to the same register in this cycle is not yet visible in
  // the register file read data, so the write-back value is taken instead.
  function automatic logic [XLEN-1:0] capture_operand(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rf_data,
    input logic            we,
    input logic [4:0]      wrd,
    input logic [XLEN-1:0] wdata
  );
    if (rs == 5'd0)
      return '0;
    else if (we && (wrd != 5'd0) && (wrd == rs))
      return wdata;
    else
      return rf_data;
  endfunction

  // Operand of an instruction that is stalled in this stage. It is kept
  // current with any write-back to its source register.
  function automatic logic [XLEN-1:0] refresh_operand(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] held,
    input logic            we,
    input logic [4:0]      wrd,
    input logic [XLEN-1:0] wdata
  );
    if (we && (wrd != 5'd0) && (wrd == rs))
      return wdata;
    else
      return held;
  endfunction

  // Bubble counter increment that holds at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    if (c == 16'hFFFF)
      return c;
    else
      return c + 16'd1;
  endfunction

  logic hazard_hit;
  logic capture;
  logic consume;
  logic bubble;
  logic hold;

  // A held load whose destination is read by the decode instruction cannot
  // forward its result yet, so decode must wait one cycle.
  assign hazard_hit = out_valid && ctrl_q[MEM_READ_BIT] && (rd_q != 5'd0) &&
                      ((rd_q == rs1_in) || (rd_q == rs2_in));
  assign load_use_stall = in_valid && hazard_hit;

  assign in_ready = (!out_valid || out_ready) && !load_use_stall && !flush;

  assign capture  = in_valid && in_ready;
  assign consume  = out_valid && out_ready;
  assign bubble   = out_ready && load_use_stall && !flush;
  assign hold     = out_valid && !out_ready && !flush;

  // Stage occupancy: flush clears it, a capture sets it, and a consume with
  // nothing new arriving empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out_valid <= 1'b0;
    else if (flush)
      out_valid <= 1'b0;
    else if (capture)
      out_valid <= 1'b1;
    else if (consume)
      out_valid <= 1'b0;
  end

  // Decode -> execute boundary: load every field on capture. While execute
  // back-pressures, keep the operands current with write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ctrl_q     <= '0;
      alu_ctrl_q <= '0;
    end else if (capture) begin
      pc_q       <= pc_in;
      rd1_q      <= capture_operand(rs1_in, rd1_in, wb_we, wb_rd, wb_data);
      rd2_q      <= capture_operand(rs2_in, rd2_in, wb_we, wb_rd, wb_data);
      imm_q      <= imm_in;
      rs1_q      <= rs1_in;
      rs2_q      <= rs2_in;
      rd_q       <= rd_in;
      ctrl_q     <= ctrl_in;
      alu_ctrl_q <= alu_ctrl_in;
    end else if (hold) begin
      rd1_q      <= refresh_operand(rs1_q, rd1_q, wb_we, wb_rd, wb_data);
      rd2_q      <= refresh_operand(rs2_q, rd2_q, wb_we, wb_rd, wb_data);
    end
  end

  // Count each bubble inserted for a load-use hazard. Flushes are not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bubble_count <= '0;
    else if (bubble)
      bubble_count <= sat_inc(bubble_count);
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg. Each instruction's expected execute
// view is queued when it is driven, then popped and compared when execute
// accepts it.
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc_in;
  logic [4:0]  rs1_in, rs2_in, rd_in;
  logic [31:0] rd1_in, rd2_in, imm_in;
  logic [7:0]  ctrl_in;
  logic [3:0]  alu_ctrl_in;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc_q, rd1_q, rd2_q, imm_q;
  logic [4:0]  rs1_q, rs2_q, rd_q;
  logic [7:0]  ctrl_q;
  logic [3:0]  alu_ctrl_q;
  logic        load_use_stall;
  logic [15:0] bubble_count;

  id_ex_stage_reg #(.XLEN(32), .ALUW(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in),
    .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
    .ctrl_in(ctrl_in), .alu_ctrl_in(alu_ctrl_in),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_q(pc_q), .rd1_q(rd1_q), .rd2_q(rd2_q), .imm_q(imm_q),
    .rs1_q(rs1_q), .rs2_q(rs2_q), .rd_q(rd_q),
    .ctrl_q(ctrl_q), .alu_ctrl_q(alu_ctrl_q),
    .load_use_stall(load_use_stall), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
    logic [3:0]  alu;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [31:0] pc, input logic [4:0] r1,
                     input logic [4:0] r2, input logic [4:0] rd,
                     input logic [31:0] d1, input logic [31:0] d2,
                     input logic [31:0] imm, input logic [7:0] ctrl,
                     input logic [3:0] alu);
    in_valid = v; pc_in = pc; rs1_in = r1; rs2_in = r2; rd_in = rd;
    rd1_in = d1; rd2_in = d2; imm_in = imm; ctrl_in = ctrl; alu_ctrl_in = alu;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] d1,
                      input logic [31:0] d2, input logic [31:0] imm,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic [7:0] ctrl,
                      input logic [3:0] alu);
    exp_t e;
    e.pc = pc; e.rd1 = d1; e.rd2 = d2; e.imm = imm;
    e.rs1 = r1; e.rs2 = r2; e.rd = rd; e.ctrl = ctrl; e.alu = alu;
    exp_q.push_back(e);
  endtask

  // Compare the instruction execute is accepting this cycle with the queue head.
  task automatic consume(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_pc"},  pc_q,  e.pc);
      chk({tag, "_rd1"}, rd1_q, e.rd1);
      chk({tag, "_rd2"}, rd2_q, e.rd2);
      chk({tag, "_imm"}, imm_q, e.imm);
      chk({tag, "_idx_ctrl"}, {5'b0, rs1_q, rs2_q, rd_q, ctrl_q, alu_ctrl_q},
          {5'b0, e.rs1, e.rs2, e.rd, e.ctrl, e.alu});
    end
  endtask

  initial begin
    rst = 1'b1;
    drv(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 8'h0, 4'h0);
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0; flush = 1'b0; out_ready = 1'b0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", pc_q, 32'h0);
    chk("rst_rd1", rd1_q, 32'h0);
    chk("rst_bubbles", 32'(bubble_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Capture with write-back bypass on rs1.
    drv(1'b1, 32'h100, 5'd5, 5'd7, 5'd9, 32'hA, 32'h66, 32'h4, 8'h80, 4'h2);
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hBEEF; out_ready = 1'b0;
    #1;
    chk("cap_in_ready", 32'(in_ready), 32'd1);
    push(32'h100, 32'hBEEF, 32'h66, 32'h4, 5'd5, 5'd7, 5'd9, 8'h80, 4'h2);
    tick();
    chk("cap_out_valid", 32'(out_valid), 32'd1);
    chk("cap_rd1", rd1_q, 32'hBEEF);
    chk("cap_pc", pc_q, 32'h100);

    // Hold under back-pressure; write-back refreshes rd2.
    drv(1'b1, 32'h104, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 8'h80, 4'h0);
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h55;
    #1;
    chk("hold_in_ready", 32'(in_ready), 32'd0);
    exp_q[0].rd2 = 32'h55;
    tick();
    chk("hold_rd2", rd2_q, 32'h55);
    chk("hold_rd1", rd1_q, 32'hBEEF);
    chk("hold_pc", pc_q, 32'h100);
    chk("hold_out_valid", 32'(out_valid), 32'd1);

    // Drain with nothing behind it.
    in_valid = 1'b0; wb_we = 1'b0; out_ready = 1'b1;
    #1;
    consume("drain");
    tick();
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_pc_hold", pc_q, 32'h100);

    // Back-to-back stream. The first entry is a load to x0; the next reads x0
    // with nonzero register data. That must not stall, and it must capture 0.
    for (int i = 0; i < 4; i++) begin
      logic [4:0]  r1;
      logic [31:0] d1, e1;
      logic [7:0]  c;
      logic [4:0]  rd;
      r1 = (i == 1) ? 5'd0 : 5'(i + 1);
      d1 = (i == 1) ? 32'hFFFF_FFFF : 32'h1000 + 32'(i);
      e1 = (i == 1) ? 32'h0 : d1;
      c  = (i == 0) ? 8'hC1 : 8'h90;
      rd = (i == 0) ? 5'd0 : 5'(16 + i);
      drv(1'b1, 32'h200 + 32'(4 * i), r1, 5'(10 + i), rd, d1, 32'h2000 + 32'(i),
          32'(i), c, 4'(i));
      #1;
      chk("tp_in_ready", 32'(in_ready), 32'd1);
      chk("tp_stall", 32'(load_use_stall), 32'd0);
      if (exp_q.size() != 0)
        consume("tp");
      else
        chk("tp_empty_out_valid", 32'(out_valid), 32'd0);
      push(32'h200 + 32'(4 * i), e1, 32'h2000 + 32'(i), 32'(i), r1, 5'(10 + i), rd, c, 4'(i));
      tick();
    end
    in_valid = 1'b0;
    #1;
    consume("tp_last");
    tick();
    chk("tp_end_out_valid", 32'(out_valid), 32'd0);

    // Load-use hazard: bubble, then capture using the load result from bypass.
    drv(1'b1, 32'h300, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h8, 8'hC1, 4'h0);
    out_ready = 1'b0;
    #1;
    chk("ld_in_ready", 32'(in_ready), 32'd1);
    push(32'h300, 32'h11, 32'h22, 32'h8, 5'd1, 5'd2, 5'd3, 8'hC1, 4'h0);
    tick();
    drv(1'b1, 32'h304, 5'd3, 5'd4, 5'd5, 32'h0, 32'h44, 32'hC, 8'hC1, 4'h1);
    out_ready = 1'b1;
    #1;
    chk("lu_stall", 32'(load_use_stall), 32'd1);
    chk("lu_in_ready", 32'(in_ready), 32'd0);
    consume("lu_load");
    tick();
    chk("lu_bubble_valid", 32'(out_valid), 32'd0);
    chk("lu_bubble_count", 32'(bubble_count), 32'd1);
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDA7A;
    #1;
    chk("lu_stall_drop", 32'(load_use_stall), 32'd0);
    chk("lu_in_ready2", 32'(in_ready), 32'd1);
    push(32'h304, 32'hDA7A, 32'h44, 32'hC, 5'd3, 5'd4, 5'd5, 8'hC1, 4'h1);
    tick();
    wb_we = 1'b0;
    chk("lu_cap_valid", 32'(out_valid), 32'd1);
    chk("lu_cap_rd1", rd1_q, 32'hDA7A);

    // Flush while a hazard is also present: no capture and no bubble count.
    drv(1'b1, 32'h308, 5'd6, 5'd5, 5'd7, 32'h6, 32'h5, 32'h0, 8'h80, 4'h0);
    flush = 1'b1; out_ready = 1'b1;
    #1;
    chk("fl_stall", 32'(load_use_stall), 32'd1);
    chk("fl_in_ready", 32'(in_ready), 32'd0);
    consume("fl_held");
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_bubble_count", 32'(bubble_count), 32'd1);
    chk("fl_pc_hold", pc_q, 32'h304);

    // Asynchronous reset while an instruction is held.
    drv(1'b1, 32'h500, 5'd8, 5'd9, 5'd10, 32'h1234, 32'h99, 32'h0, 8'h80, 4'h3);
    out_ready = 1'b0;
    #1;
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    chk("ar_pre_rd1", rd1_q, 32'h1234);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_rd1", rd1_q, 32'h0);
    chk("ar_pc", pc_q, 32'h0);
    chk("ar_idx_ctrl", {5'b0, rs1_q, rs2_q, rd_q, ctrl_q, alu_ctrl_q}, 32'h0);
    chk("ar_bubbles", 32'(bubble_count), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("ar_after_valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
